// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions the raw push-button pins for the Atari 2600 core: each pin is
// synchronized, optionally inverted, and debounced into a clean level with
// one-cycle press/release pulses. Also generates the core's active-low system
// reset from a power-on stretch and a long press on one designated button.
//
// Ports:
//   clk          pixel clock, everything on its rising edge
//   rst          synchronous active-high reset
//   btn_raw      asynchronous button pins
//   btn_level    debounced level per button, 1 = pressed
//   btn_press    one-cycle pulse on a debounced 0->1 transition
//   btn_release  one-cycle pulse on a debounced 1->0 transition
//   hold_active  high while a long-press reset is in progress
//   sys_rst_n    registered active-low reset for the core
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int                 N_BTN           = 4,
    parameter logic [N_BTN-1:0]   ACTIVE_LOW_MASK = 4'b0001,
    parameter int                 DEBOUNCE_CYCLES = 250000,
    parameter int                 HOLD_CYCLES     = 25200000,
    parameter int                 RESET_IDX       = 0,
    parameter int                 POR_CYCLES      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             hold_active,
    output logic             sys_rst_n
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int POR_W  = $clog2(POR_CYCLES + 1);

    // Counter value on which the next mismatching cycle completes the run.
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [POR_W-1:0]  POR_LAST = POR_W'(POR_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizer, polarity normalized afterwards
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync2_reg;
    logic [N_BTN-1:0] btn_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign btn_sync = sync2_reg ^ ACTIVE_LOW_MASK;

    // ------------------------------------------------------------------
    // Per-button debounce
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] level_reg;
    logic [N_BTN-1:0] level_next;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_debounce
        logic [DB_W-1:0] cnt_reg;
        logic [DB_W-1:0] cnt_next;
        logic            lvl_reg;
        logic            lvl_next;

        always_comb begin
            cnt_next = '0;
            lvl_next = lvl_reg;
            if (btn_sync[gi] != lvl_reg) begin
                // Toggle on the cycle the count would reach DEBOUNCE_CYCLES.
                if (cnt_reg == DB_LAST) begin
                    lvl_next = ~lvl_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
                lvl_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_next;
                lvl_reg <= lvl_next;
            end
        end

        assign level_reg[gi]  = lvl_reg;
        assign level_next[gi] = lvl_next;
    end

    // Pulses are registered from the next-level value so they line up with
    // the first cycle btn_level shows the new value.
    logic [N_BTN-1:0] press_reg;
    logic [N_BTN-1:0] release_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            press_reg   <= '0;
            release_reg <= '0;
        end else begin
            press_reg   <= level_next & ~level_reg;
            release_reg <= level_reg & ~level_next;
        end
    end

    // ------------------------------------------------------------------
    // Long-press detector on the reset button (saturating counter)
    // ------------------------------------------------------------------
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              hold_active_reg;
    logic              hold_active_next;

    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (!level_reg[RESET_IDX]) begin
            hold_cnt_next = '0;
        end else if (hold_cnt_reg != HOLD_MAX) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end
        hold_active_next = level_reg[RESET_IDX] && (hold_cnt_next == HOLD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_reg    <= '0;
            hold_active_reg <= 1'b0;
        end else begin
            hold_cnt_reg    <= hold_cnt_next;
            hold_active_reg <= hold_active_next;
        end
    end

    // ------------------------------------------------------------------
    // System reset sequencer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [POR_W-1:0] por_cnt_reg;
    logic [POR_W-1:0] por_cnt_next;
    logic             sys_rst_n_reg;

    always_comb begin
        state_next   = state_reg;
        por_cnt_next = por_cnt_reg;
        case (state_reg)
            ST_POR: begin
                // A long press during the stretch pins the count at zero.
                if (hold_active_reg) begin
                    por_cnt_next = '0;
                end else if (por_cnt_reg == POR_LAST) begin
                    state_next   = ST_RUN;
                    por_cnt_next = '0;
                end else begin
                    por_cnt_next = por_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (hold_active_reg) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!hold_active_reg) begin
                    state_next   = ST_POR;
                    por_cnt_next = '0;
                end
            end
            default: begin
                state_next   = ST_POR;
                por_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_POR;
            por_cnt_reg   <= '0;
            sys_rst_n_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            por_cnt_reg   <= por_cnt_next;
            // Decoded from the next state so the output is a clean flop.
            sys_rst_n_reg <= (state_next == ST_RUN);
        end
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;
    assign hold_active = hold_active_reg;
    assign sys_rst_n   = sys_rst_n_reg;

endmodule
